// File: rtl/intc.sv
// Interrupt controller for a UIB slave port: synchronises and latches source
// events, masks them, and drives a single registered intr to the cpu.
module intc #(
    parameter int NSRC = 8,
    parameter int XLEN = 32,
    parameter int AW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic [XLEN-1:0] dat_i,
    output logic [XLEN-1:0] dat_o,
    input  logic [AW-1:0]   addr,
    input  logic [2:0]      mode,
    input  logic            wen,
    input  logic            req,
    output logic            ready,
    output logic            intr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [2:0] IDX_PENDING = 3'd0;
    localparam logic [2:0] IDX_ENABLE  = 3'd1;
    localparam logic [2:0] IDX_CLAIM   = 3'd2;
    localparam logic [2:0] IDX_TRIG    = 3'd3;
    localparam logic [2:0] IDX_SWSET   = 3'd4;

    logic [1:0]      state;
    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] pending, enable, trig, insvc;
    logic [NSRC-1:0] eligible, claim_bit, done_bit, src_set;
    logic [NSRC-1:0] claim_clr, done_clr, sw_set;
    logic [XLEN-1:0] wmask, wval, rdata, claim_id;
    logic [2:0]      idx;
    logic            hit, access, wr, rd;
    logic            unused_addr;

    assign unused_addr = ^addr[1:0];

    assign idx    = addr[4:2];
    assign hit    = (addr[AW-1:5] == '0) && (idx <= IDX_SWSET);
    assign access = (state == ST_IDLE) && req;
    assign wr     = access && wen && hit;
    assign rd     = access && !wen && hit;
    assign ready  = (state == ST_ACK);

    always_comb begin
        case (mode)
            3'b000:  wmask = XLEN'(8'hFF);
            3'b001:  wmask = XLEN'(16'hFFFF);
            default: wmask = '1;
        endcase
    end

    assign wval     = dat_i & wmask;
    assign eligible = pending & enable & ~insvc;

    // Lowest-numbered eligible source wins; claim_id stays 0 when none is eligible.
    always_comb begin
        claim_bit = '0;
        claim_id  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (eligible[i] && claim_id == '0) begin
                claim_bit[i] = 1'b1;
                claim_id     = XLEN'(i + 1);
            end
        end
    end

    always_comb begin
        done_bit = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            done_bit[i] = (wval == XLEN'(i + 1));
        end
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (idx)
                IDX_PENDING: rdata = XLEN'(pending);
                IDX_ENABLE:  rdata = XLEN'(enable);
                IDX_CLAIM:   rdata = claim_id;
                IDX_TRIG:    rdata = XLEN'(trig);
                default:     rdata = '0;
            endcase
        end
    end

    assign src_set   = (trig & s2 & ~s3) | (~trig & s2 & ~insvc);
    assign claim_clr = (rd && idx == IDX_CLAIM) ? claim_bit : '0;
    assign done_clr  = (wr && idx == IDX_CLAIM) ? done_bit : '0;
    assign sw_set    = (wr && idx == IDX_SWSET) ? wval[NSRC-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= src;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // New events are OR-ed in after the claim clear so a same-cycle set survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            insvc   <= '0;
            enable  <= '0;
            trig    <= '0;
            intr    <= 1'b0;
        end else begin
            pending <= (pending & ~claim_clr) | src_set | sw_set;
            insvc   <= (insvc | claim_clr) & ~done_clr;
            if (wr && idx == IDX_ENABLE)
                enable <= (enable & ~wmask[NSRC-1:0]) | wval[NSRC-1:0];
            if (wr && idx == IDX_TRIG)
                trig <= (trig & ~wmask[NSRC-1:0]) | wval[NSRC-1:0];
            intr <= (|(pending & enable)) & ~(|insvc);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            dat_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_ACK;
                        dat_o <= wen ? '0 : rdata;
                    end
                end
                ST_ACK: begin
                    state <= ST_HOLD;
                    dat_o <= '0;
                end
                ST_HOLD: begin
                    if (!req)
                        state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    dat_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intc.sv
// Scenario bench for intc: bus reads are scored against a queue of expected
// values pushed as each access is issued.
module tb_intc;
    localparam int NSRC = 12;
    localparam int XLEN = 32;
    localparam int AW   = 16;

    localparam logic [AW-1:0] A_PEND  = 16'h0000;
    localparam logic [AW-1:0] A_EN    = 16'h0004;
    localparam logic [AW-1:0] A_CLAIM = 16'h0008;
    localparam logic [AW-1:0] A_TRIG  = 16'h000C;
    localparam logic [AW-1:0] A_SWSET = 16'h0010;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] src;
    logic [XLEN-1:0] dat_i, dat_o;
    logic [AW-1:0]   addr;
    logic [2:0]      mode;
    logic            wen, req, ready, intr;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    intc #(.NSRC(NSRC), .XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst), .src(src), .dat_i(dat_i), .dat_o(dat_o),
        .addr(addr), .mode(mode), .wen(wen), .req(req), .ready(ready), .intr(intr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [2:0] m);
        int n = 0;
        addr = a; dat_i = d; mode = m; wen = 1'b1; req = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 20);
        vectors++;
        if (!ready) begin
            miscompares++;
            $display("FAIL write_ack addr=%h ready=0 required 1", a);
        end
        req = 1'b0; wen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
        int n = 0;
        addr = a; mode = 3'b010; wen = 1'b0; req = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 20);
        vectors++;
        if (!ready) begin
            miscompares++;
            $display("FAIL read_ack addr=%h ready=0 required 1", a);
        end
        d = dat_o;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d, e;
        int n = 0;
        rst = 1'b1; src = '0; req = 1'b0; wen = 1'b0; addr = '0; dat_i = '0; mode = 3'b010;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if (ready !== 1'b0 || intr !== 1'b0 || dat_o !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs ready=%b intr=%b dat_o=%h required 0 0 0", ready, intr, dat_o);
        end
        bus_write(A_EN, 32'h1, 3'b010);
        src[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (intr !== 1'b1) begin miscompares++; $display("FAIL reset_pre_intr got %b required 1", intr); end
        addr = A_PEND; wen = 1'b0; req = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!ready && n < 20);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (ready !== 1'b0 || intr !== 1'b0 || dat_o !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_ack ready=%b intr=%b dat_o=%h required 0 0 0", ready, intr, dat_o);
        end
        src = '0; req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        bus_read(A_PEND, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL reset_pending got %h required %h", d, e); end
        exp_q.push_back(32'h0);
        bus_read(A_EN, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL reset_enable got %h required %h", d, e); end
    endtask

    task automatic test_level;
        logic [31:0] d, e;
        bus_write(A_EN, 32'h1, 3'b010);
        src[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (intr !== 1'b0) begin miscompares++; $display("FAIL level_intr_early got %b required 0", intr); end
        @(posedge clk);
        #1;
        vectors++;
        if (intr !== 1'b1) begin miscompares++; $display("FAIL level_intr_4clk got %b required 1", intr); end
        exp_q.push_back(32'h1);
        bus_read(A_CLAIM, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL level_claim got %h required %h", d, e); end
        vectors++;
        if (intr !== 1'b0) begin miscompares++; $display("FAIL level_intr_after_claim got %b required 0", intr); end
        bus_write(A_CLAIM, 32'h1, 3'b010);
        vectors++;
        if (intr !== 1'b1) begin miscompares++; $display("FAIL level_intr_after_complete got %b required 1", intr); end
        exp_q.push_back(32'h1);
        bus_read(A_PEND, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL level_repend got %h required %h", d, e); end
        src[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(32'h1);
        bus_read(A_CLAIM, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL level_claim2 got %h required %h", d, e); end
        bus_write(A_CLAIM, 32'h1, 3'b010);
        exp_q.push_back(32'h0);
        bus_read(A_PEND, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e || intr !== 1'b0) begin
            miscompares++;
            $display("FAIL level_idle pending=%h intr=%b required %h 0", d, intr, e);
        end
        bus_write(A_EN, 32'h0, 3'b010);
    endtask

    task automatic test_edge;
        logic [31:0] d, e;
        bus_write(A_TRIG, 32'h4, 3'b010);
        bus_write(A_EN, 32'h4, 3'b010);
        src[2] = 1'b1;
        @(posedge clk);
        #1 src[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (intr !== 1'b1) begin miscompares++; $display("FAIL edge_intr got %b required 1", intr); end
        exp_q.push_back(32'h4);
        bus_read(A_PEND, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL edge_pending got %h required %h", d, e); end
        exp_q.push_back(32'h3);
        bus_read(A_CLAIM, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL edge_claim got %h required %h", d, e); end
        exp_q.push_back(32'h0);
        bus_read(A_PEND, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL edge_pending_cleared got %h required %h", d, e); end
        src[2] = 1'b1;
        @(posedge clk);
        #1 src[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(32'h4);
        bus_read(A_PEND, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e || intr !== 1'b0) begin
            miscompares++;
            $display("FAIL edge_in_service pending=%h intr=%b required %h 0", d, intr, e);
        end
        bus_write(A_CLAIM, 32'h3, 3'b010);
        vectors++;
        if (intr !== 1'b1) begin miscompares++; $display("FAIL edge_intr_after_complete got %b required 1", intr); end
        exp_q.push_back(32'h3);
        bus_read(A_CLAIM, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL edge_claim2 got %h required %h", d, e); end
        bus_write(A_CLAIM, 32'h3, 3'b010);
        bus_write(A_TRIG, 32'h0, 3'b010);
        bus_write(A_EN, 32'h0, 3'b010);
        vectors++;
        if (intr !== 1'b0) begin miscompares++; $display("FAIL edge_idle_intr got %b required 0", intr); end
    endtask

    task automatic test_priority;
        logic [31:0] d, e;
        bus_write(A_SWSET, 32'h0A, 3'b010);
        bus_write(A_EN, 32'hFF, 3'b010);
        vectors++;
        if (intr !== 1'b1) begin miscompares++; $display("FAIL prio_intr got %b required 1", intr); end
        exp_q.push_back(32'h2);
        bus_read(A_CLAIM, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL prio_claim_first got %h required %h", d, e); end
        bus_write(A_CLAIM, NSRC + 1, 3'b010);
        vectors++;
        if (intr !== 1'b0) begin miscompares++; $display("FAIL prio_bad_complete_hi intr=%b required 0", intr); end
        bus_write(A_CLAIM, 32'h0, 3'b010);
        vectors++;
        if (intr !== 1'b0) begin miscompares++; $display("FAIL prio_bad_complete_0 intr=%b required 0", intr); end
        bus_write(A_CLAIM, 32'h2, 3'b010);
        vectors++;
        if (intr !== 1'b1) begin miscompares++; $display("FAIL prio_complete intr=%b required 1", intr); end
        exp_q.push_back(32'h4);
        bus_read(A_CLAIM, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL prio_claim_second got %h required %h", d, e); end
        bus_write(A_CLAIM, 32'h4, 3'b010);
        exp_q.push_back(32'h0);
        bus_read(A_CLAIM, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL prio_claim_empty got %h required %h", d, e); end
        exp_q.push_back(32'h0);
        bus_read(A_PEND, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e || intr !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_idle pending=%h intr=%b required %h 0", d, intr, e);
        end
    endtask

    task automatic test_bus;
        logic [31:0] d, e;
        int rdy_cnt = 0;
        int first = -1;
        bus_write(A_SWSET, 32'h3, 3'b010);
        d = '0;
        exp_q.push_back(32'h1);
        addr = A_CLAIM; wen = 1'b0; mode = 3'b010; req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                rdy_cnt++;
                if (first < 0) first = i;
                d = dat_o;
            end
        end
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (rdy_cnt != 1 || first != 1) begin
            miscompares++;
            $display("FAIL bus_held_req pulses=%0d first=%0d required 1 1", rdy_cnt, first);
        end
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_held_claim got %h required %h", d, e); end
        exp_q.push_back(32'h2);
        bus_read(A_PEND, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_single_claim pending=%h required %h", d, e); end
        vectors++;
        if (dat_o !== '0) begin miscompares++; $display("FAIL bus_idle_dat_o got %h required 0", dat_o); end
        bus_write(A_CLAIM, 32'h1, 3'b010);
        exp_q.push_back(32'h2);
        bus_read(A_CLAIM, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_claim_rest got %h required %h", d, e); end
        bus_write(A_CLAIM, 32'h2, 3'b010);

        bus_write(A_EN, 32'h0, 3'b010);
        bus_write(A_EN, 32'hFFFFFFFF, 3'b000);
        exp_q.push_back(32'h0FF);
        bus_read(A_EN, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_byte_write got %h required %h", d, e); end
        bus_write(A_EN, 32'hFFFFFFFF, 3'b001);
        exp_q.push_back(32'hFFF);
        bus_read(A_EN, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_half_write got %h required %h", d, e); end
        bus_write(A_EN, 32'h5A5, 3'b010);
        bus_write(A_EN, 32'hFFFFFF00, 3'b000);
        exp_q.push_back(32'h500);
        bus_read(A_EN, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_byte_lane got %h required %h", d, e); end
        bus_write(16'h0044, 32'h0, 3'b010);
        exp_q.push_back(32'h500);
        bus_read(A_EN, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_oob_write got %h required %h", d, e); end
        exp_q.push_back(32'h0);
        bus_read(16'h0040, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_oob_read got %h required %h", d, e); end
        exp_q.push_back(32'h0);
        bus_read(16'h0014, d);
        e = exp_q.pop_front();
        vectors++;
        if (d !== e) begin miscompares++; $display("FAIL bus_idx5_read got %h required %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_edge();
        test_priority();
        test_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
